// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass mux and load-use stall sequencing.
// A load in EX that feeds the instruction in ID costs one bubble. A second bubble
// is added if the load is still in MEM and not yet forwardable (loadHazard_i).
// PC and IF/ID are frozen through stallIF_o while the ID instruction waits.
// Optional feature macro: ID_EX_STATS_EN adds saturating bubble/bypass counters
// (bubbleCount_o, bypassCount_o).
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              validID_i,
  input  logic [REG_W-1:0]  readRegRsID_i,
  input  logic [REG_W-1:0]  readRegRtID_i,
  input  logic [REG_W-1:0]  writeRegID_i,
  input  logic              regWriteID_i,
  input  logic              memReadID_i,
  input  logic [CTRL_W-1:0] ctrlID_i,
  input  logic [DATA_W-1:0] readData1ID_i,
  input  logic [DATA_W-1:0] readData2ID_i,
  input  logic [DATA_W-1:0] immID_i,
  input  logic              bypassingControl1_i,
  input  logic              bypassingControl2_i,
  input  logic [DATA_W-1:0] bypassingResult1_i,
  input  logic [DATA_W-1:0] bypassingResult2_i,
  input  logic              loadHazard_i,
  output logic              stallIF_o,
  output logic              validEX_o,
  output logic [DATA_W-1:0] operandAEX_o,
  output logic [DATA_W-1:0] operandBEX_o,
  output logic [DATA_W-1:0] immEX_o,
  output logic [CTRL_W-1:0] ctrlEX_o,
  output logic              regWriteEX_o,
  output logic              memReadEX_o,
  output logic [REG_W-1:0]  writeRegEX_o,
  output logic [REG_W-1:0]  readRegRsEX_o,
  output logic [REG_W-1:0]  readRegRtEX_o
`ifdef ID_EX_STATS_EN
  ,
  output logic [STAT_W-1:0] bubbleCount_o,
  output logic [STAT_W-1:0] bypassCount_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WAIT_WB  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Registered EX-side state
  logic              valid_ex_reg;
  logic [DATA_W-1:0] operand_a_reg;
  logic [DATA_W-1:0] operand_b_reg;
  logic [DATA_W-1:0] imm_ex_reg;
  logic [CTRL_W-1:0] ctrl_ex_reg;
  logic              reg_write_ex_reg;
  logic              mem_read_ex_reg;
  logic [REG_W-1:0]  write_reg_ex_reg;
  logic [REG_W-1:0]  rs_ex_reg;
  logic [REG_W-1:0]  rt_ex_reg;

  // Per-operand views so both source paths share one generate body
  logic [DATA_W-1:0] rf_data     [2];
  logic [DATA_W-1:0] byp_data    [2];
  logic [DATA_W-1:0] operand_mux [2];
  logic [REG_W-1:0]  src_idx     [2];
  logic [1:0]        byp_sel;
  logic [1:0]        src_match;

  logic load_use;
  logic do_latch;
  logic stall;

  assign rf_data[0]  = readData1ID_i;
  assign rf_data[1]  = readData2ID_i;
  assign byp_data[0] = bypassingResult1_i;
  assign byp_data[1] = bypassingResult2_i;
  assign src_idx[0]  = readRegRsID_i;
  assign src_idx[1]  = readRegRtID_i;
  assign byp_sel     = {bypassingControl2_i, bypassingControl1_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // Forwarded value wins over the register-file read
      assign operand_mux[gi] = byp_sel[gi] ? byp_data[gi] : rf_data[gi];
      // Does the load destination in EX feed this source operand?
      assign src_match[gi]   = (write_reg_ex_reg == src_idx[gi]);
    end
  endgenerate

  // r0 is hard-wired, so a load into r0 never creates a dependency
  assign load_use = valid_ex_reg & mem_read_ex_reg & reg_write_ex_reg &
                    (write_reg_ex_reg != '0) & validID_i & (|src_match);

  // Per-cycle decision: latch or bubble, whether to freeze IF, and the next state
  always_comb begin
    state_next = ST_RUN;
    do_latch   = 1'b0;
    stall      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (flush_i) begin
          do_latch = 1'b0;
        end else if (load_use) begin
          stall      = 1'b1;
          state_next = ST_WAIT_MEM;
        end else if (loadHazard_i && validID_i) begin
          // No real instruction in ID means nothing needs to wait
          stall = 1'b1;
        end else begin
          do_latch = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        if (flush_i) begin
          do_latch = 1'b0;
        end else if (loadHazard_i) begin
          stall      = 1'b1;
          state_next = ST_WAIT_WB;
        end else begin
          do_latch = 1'b1;
        end
      end
      ST_WAIT_WB: begin
        // Write-before-read register file already holds the load result
        do_latch = !flush_i;
      end
      default: begin
        do_latch = 1'b0;
      end
    endcase
    // The reset cycle never freezes fetch
    if (rst) begin
      stall = 1'b0;
    end
  end

  assign stallIF_o = stall;

  // State and EX register update: a bubble clears controls and keeps data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_RUN;
      valid_ex_reg     <= 1'b0;
      operand_a_reg    <= '0;
      operand_b_reg    <= '0;
      imm_ex_reg       <= '0;
      ctrl_ex_reg      <= '0;
      reg_write_ex_reg <= 1'b0;
      mem_read_ex_reg  <= 1'b0;
      write_reg_ex_reg <= '0;
      rs_ex_reg        <= '0;
      rt_ex_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (do_latch) begin
        valid_ex_reg     <= validID_i;
        operand_a_reg    <= operand_mux[0];
        operand_b_reg    <= operand_mux[1];
        imm_ex_reg       <= immID_i;
        ctrl_ex_reg      <= ctrlID_i;
        reg_write_ex_reg <= regWriteID_i;
        mem_read_ex_reg  <= memReadID_i;
        write_reg_ex_reg <= writeRegID_i;
        rs_ex_reg        <= readRegRsID_i;
        rt_ex_reg        <= readRegRtID_i;
      end else begin
        valid_ex_reg     <= 1'b0;
        ctrl_ex_reg      <= '0;
        reg_write_ex_reg <= 1'b0;
        mem_read_ex_reg  <= 1'b0;
        write_reg_ex_reg <= '0;
      end
    end
  end

  assign validEX_o     = valid_ex_reg;
  assign operandAEX_o  = operand_a_reg;
  assign operandBEX_o  = operand_b_reg;
  assign immEX_o       = imm_ex_reg;
  assign ctrlEX_o      = ctrl_ex_reg;
  assign regWriteEX_o  = reg_write_ex_reg;
  assign memReadEX_o   = mem_read_ex_reg;
  assign writeRegEX_o  = write_reg_ex_reg;
  assign readRegRsEX_o = rs_ex_reg;
  assign readRegRtEX_o = rt_ex_reg;

`ifdef ID_EX_STATS_EN
  logic [STAT_W-1:0] bubble_count_reg;
  logic [STAT_W-1:0] bypass_count_reg;

  // Saturating counters: every non-latch cycle is a bubble; forwarded latches count as bypasses
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_reg <= '0;
      bypass_count_reg <= '0;
    end else begin
      if (!do_latch && (bubble_count_reg != '1)) begin
        bubble_count_reg <= bubble_count_reg + 1'b1;
      end
      if (do_latch && (|byp_sel) && (bypass_count_reg != '1)) begin
        bypass_count_reg <= bypass_count_reg + 1'b1;
      end
    end
  end

  assign bubbleCount_o = bubble_count_reg;
  assign bypassCount_o = bypass_count_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, plain latch, bypass, one- and two-bubble
// load-use, flush in WAIT_MEM, r0 load, idle ID, reset mid-stall, and counters.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 8;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              validID_i;
  logic [REG_W-1:0]  readRegRsID_i;
  logic [REG_W-1:0]  readRegRtID_i;
  logic [REG_W-1:0]  writeRegID_i;
  logic              regWriteID_i;
  logic              memReadID_i;
  logic [CTRL_W-1:0] ctrlID_i;
  logic [DATA_W-1:0] readData1ID_i;
  logic [DATA_W-1:0] readData2ID_i;
  logic [DATA_W-1:0] immID_i;
  logic              bypassingControl1_i;
  logic              bypassingControl2_i;
  logic [DATA_W-1:0] bypassingResult1_i;
  logic [DATA_W-1:0] bypassingResult2_i;
  logic              loadHazard_i;
  logic              stallIF_o;
  logic              validEX_o;
  logic [DATA_W-1:0] operandAEX_o;
  logic [DATA_W-1:0] operandBEX_o;
  logic [DATA_W-1:0] immEX_o;
  logic [CTRL_W-1:0] ctrlEX_o;
  logic              regWriteEX_o;
  logic              memReadEX_o;
  logic [REG_W-1:0]  writeRegEX_o;
  logic [REG_W-1:0]  readRegRsEX_o;
  logic [REG_W-1:0]  readRegRtEX_o;
`ifdef ID_EX_STATS_EN
  logic [STAT_W-1:0] bubbleCount_o;
  logic [STAT_W-1:0] bypassCount_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .STAT_W(STAT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .validID_i           (validID_i),
    .readRegRsID_i       (readRegRsID_i),
    .readRegRtID_i       (readRegRtID_i),
    .writeRegID_i        (writeRegID_i),
    .regWriteID_i        (regWriteID_i),
    .memReadID_i         (memReadID_i),
    .ctrlID_i            (ctrlID_i),
    .readData1ID_i       (readData1ID_i),
    .readData2ID_i       (readData2ID_i),
    .immID_i             (immID_i),
    .bypassingControl1_i (bypassingControl1_i),
    .bypassingControl2_i (bypassingControl2_i),
    .bypassingResult1_i  (bypassingResult1_i),
    .bypassingResult2_i  (bypassingResult2_i),
    .loadHazard_i        (loadHazard_i),
    .stallIF_o           (stallIF_o),
    .validEX_o           (validEX_o),
    .operandAEX_o        (operandAEX_o),
    .operandBEX_o        (operandBEX_o),
    .immEX_o             (immEX_o),
    .ctrlEX_o            (ctrlEX_o),
    .regWriteEX_o        (regWriteEX_o),
    .memReadEX_o         (memReadEX_o),
    .writeRegEX_o        (writeRegEX_o),
    .readRegRsEX_o       (readRegRsEX_o),
    .readRegRtEX_o       (readRegRtEX_o)
`ifdef ID_EX_STATS_EN
    ,
    .bubbleCount_o       (bubbleCount_o),
    .bypassCount_o       (bypassCount_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [7:0] ctrl, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm);
    validID_i     = v;
    readRegRsID_i = rs;
    readRegRtID_i = rt;
    writeRegID_i  = rd;
    regWriteID_i  = rw;
    memReadID_i   = mr;
    ctrlID_i      = ctrl;
    readData1ID_i = d1;
    readData2ID_i = d2;
    immID_i       = imm;
  endtask

  task automatic set_byp(input logic c1, input logic [31:0] r1,
                         input logic c2, input logic [31:0] r2);
    bypassingControl1_i = c1;
    bypassingResult1_i  = r1;
    bypassingControl2_i = c2;
    bypassingResult2_i  = r2;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    loadHazard_i = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 8'h12, 32'h1111_1111, 32'h2222_2222, 32'h4);
    set_byp(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset: two cycles, stall suppressed even with a hazard raised
    #1;
    chk("stall_in_reset", {31'b0, stallIF_o}, 32'd0);
    tick();
    tick();
    chk("rst_valid", {31'b0, validEX_o}, 32'd0);
    chk("rst_opA", operandAEX_o, 32'd0);
    chk("rst_ctrl", {24'b0, ctrlEX_o}, 32'd0);
    chk("rst_wreg", {27'b0, writeRegEX_o}, 32'd0);
    $display("step reset: validEX=%0b opA=0x%08h", validEX_o, operandAEX_o);

    // add r3,r1,r2, no bypass
    rst = 1'b0;
    loadHazard_i = 1'b0;
    #1;
    chk("add_stall", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("add_valid", {31'b0, validEX_o}, 32'd1);
    chk("add_opA", operandAEX_o, 32'h1111_1111);
    chk("add_opB", operandBEX_o, 32'h2222_2222);
    chk("add_imm", immEX_o, 32'h4);
    chk("add_ctrl", {24'b0, ctrlEX_o}, 32'h12);
    chk("add_wreg", {27'b0, writeRegEX_o}, 32'd3);
    chk("add_rs_rt", {22'b0, readRegRsEX_o, readRegRtEX_o}, {22'b0, 5'd1, 5'd2});
    $display("step add: validEX=%0b opA=0x%08h", validEX_o, operandAEX_o);

    // Forwarded rs
    set_id(1'b1, 5'd3, 5'd3, 5'd7, 1'b1, 1'b0, 8'h21, 32'h3333_3333, 32'h3333_3333, 32'h0);
    set_byp(1'b1, 32'hDEAD_0001, 1'b0, 32'h0);
    tick();
    chk("byp1_opA", operandAEX_o, 32'hDEAD_0001);
    chk("byp1_opB", operandBEX_o, 32'h3333_3333);
    $display("step byp1: opA=0x%08h opB=0x%08h", operandAEX_o, operandBEX_o);

    // Forwarded rt
    set_id(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0, 8'h22, 32'h0000_0101, 32'h7777_7777, 32'h0);
    set_byp(1'b0, 32'hBAD0_BAD0, 1'b1, 32'hBEEF_0002);
    tick();
    chk("byp2_opA", operandAEX_o, 32'h0000_0101);
    chk("byp2_opB", operandBEX_o, 32'hBEEF_0002);
    $display("step byp2: opA=0x%08h opB=0x%08h", operandAEX_o, operandBEX_o);

    // lw r5,0(r1)
    set_byp(1'b0, 32'h0, 1'b0, 32'h0);
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 8'h40, 32'h0000_1000, 32'h0, 32'h0);
    tick();
    chk("lw_memread", {31'b0, memReadEX_o}, 32'd1);
    $display("step lw: memReadEX=%0b wreg=%0d", memReadEX_o, writeRegEX_o);

    // add r6,r5,r4 -> one bubble, then latch forwarded 0xAA
    set_id(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b0, 8'h34, 32'h0000_0055, 32'h0000_0044, 32'h0);
    #1;
    chk("lu1_stall", {31'b0, stallIF_o}, 32'd1);
    tick();
    chk("lu1_bubble_valid", {31'b0, validEX_o}, 32'd0);
    chk("lu1_bubble_ctl", {22'b0, regWriteEX_o, memReadEX_o, ctrlEX_o}, 32'd0);
    chk("lu1_bubble_wreg", {27'b0, writeRegEX_o}, 32'd0);
    chk("lu1_bubble_holdA", operandAEX_o, 32'h0000_1000);
    set_byp(1'b1, 32'h0000_00AA, 1'b0, 32'h0);
    #1;
    chk("lu1_wait_stall", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("lu1_valid", {31'b0, validEX_o}, 32'd1);
    chk("lu1_opA", operandAEX_o, 32'h0000_00AA);
    chk("lu1_opB", operandBEX_o, 32'h0000_0044);
    chk("lu1_wreg", {27'b0, writeRegEX_o}, 32'd6);
    $display("step loaduse1: validEX=%0b opA=0x%08h", validEX_o, operandAEX_o);
`ifdef ID_EX_STATS_EN
    chk("stat_bypass3", {16'b0, bypassCount_o}, 32'd3);
    chk("stat_bubble1", {16'b0, bubbleCount_o}, 32'd1);
`endif

    // Two-bubble load-use
    set_byp(1'b0, 32'h0, 1'b0, 32'h0);
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 8'h40, 32'h0000_1000, 32'h0, 32'h0);
    tick();
    set_id(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b0, 8'h34, 32'h0000_0055, 32'h0000_0044, 32'h0);
    #1;
    chk("lu2_stall1", {31'b0, stallIF_o}, 32'd1);
    tick();
    loadHazard_i = 1'b1;
    #1;
    chk("lu2_stall2", {31'b0, stallIF_o}, 32'd1);
    tick();
    chk("lu2_bubble2_valid", {31'b0, validEX_o}, 32'd0);
    loadHazard_i = 1'b0;
    #1;
    chk("lu2_wb_stall", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("lu2_valid", {31'b0, validEX_o}, 32'd1);
    chk("lu2_opA", operandAEX_o, 32'h0000_0055);
    $display("step loaduse2: validEX=%0b opA=0x%08h", validEX_o, operandAEX_o);

    // Flush while in WAIT_MEM, with a hazard raised to prove flush priority
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 8'h40, 32'h0000_2000, 32'h0, 32'h0);
    tick();
    set_id(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b0, 8'h34, 32'h0000_0055, 32'h0000_0044, 32'h0);
    #1;
    chk("fl_stall_pre", {31'b0, stallIF_o}, 32'd1);
    tick();
    flush_i = 1'b1;
    loadHazard_i = 1'b1;
    #1;
    chk("fl_stall", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("fl_valid", {31'b0, validEX_o}, 32'd0);
    // Back in RUN: a hazard with no load-use stalls for one cycle only
    flush_i = 1'b0;
    #1;
    chk("fl_run_hazard_stall", {31'b0, stallIF_o}, 32'd1);
    tick();
    chk("fl_run_hazard_valid", {31'b0, validEX_o}, 32'd0);
    loadHazard_i = 1'b0;
    #1;
    chk("fl_run_stall", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("fl_run_valid", {31'b0, validEX_o}, 32'd1);
    $display("step flush: validEX=%0b stall=%0b", validEX_o, stallIF_o);
`ifdef ID_EX_STATS_EN
    chk("stat_bubble6", {16'b0, bubbleCount_o}, 32'd6);
`endif

    // lw r0 never stalls
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 8'h40, 32'h0, 32'h0, 32'h0);
    tick();
    set_id(1'b1, 5'd0, 5'd4, 5'd6, 1'b1, 1'b0, 8'h34, 32'h0000_0000, 32'h0000_0044, 32'h0);
    #1;
    chk("r0_stall", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("r0_valid", {31'b0, validEX_o}, 32'd1);
    chk("r0_wreg", {27'b0, writeRegEX_o}, 32'd6);
    $display("step lw_r0: validEX=%0b stall=%0b", validEX_o, stallIF_o);

    // Idle ID latches an invalid slot
    set_id(1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 8'h00, 32'h9, 32'h9, 32'h0);
    #1;
    chk("idle_stall", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("idle_valid", {31'b0, validEX_o}, 32'd0);
    chk("idle_wreg", {27'b0, writeRegEX_o}, 32'd9);
    $display("step idle: validEX=%0b", validEX_o);

    // Reset mid-stall
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 8'h40, 32'h0000_3000, 32'h0, 32'h0);
    tick();
    set_id(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b0, 8'h34, 32'h0000_0055, 32'h0000_0044, 32'h0);
    #1;
    chk("rm_stall_pre", {31'b0, stallIF_o}, 32'd1);
    tick();
    rst = 1'b1;
    loadHazard_i = 1'b1;
    #1;
    chk("rm_stall_rst", {31'b0, stallIF_o}, 32'd0);
    tick();
    chk("rm_valid", {31'b0, validEX_o}, 32'd0);
    chk("rm_opA", operandAEX_o, 32'd0);
    rst = 1'b0;
    loadHazard_i = 1'b0;
    #1;
    chk("rm_stall_post", {31'b0, stallIF_o}, 32'd0);
`ifdef ID_EX_STATS_EN
    chk("rm_bubble_clr", {16'b0, bubbleCount_o}, 32'd0);
    chk("rm_bypass_clr", {16'b0, bypassCount_o}, 32'd0);
`endif
    tick();
    chk("rm_latch_valid", {31'b0, validEX_o}, 32'd1);
    chk("rm_latch_opA", operandAEX_o, 32'h0000_0055);
    $display("step rst_mid_stall: validEX=%0b opA=0x%08h", validEX_o, operandAEX_o);

`ifdef ID_EX_STATS_EN
    // Saturation: 2^STAT_W flush bubbles
    flush_i = 1'b1;
    repeat (1 << STAT_W) tick();
    chk("sat_bubble", {16'b0, bubbleCount_o}, 32'h0000_FFFF);
    tick();
    chk("sat_bubble_hold", {16'b0, bubbleCount_o}, 32'h0000_FFFF);
    flush_i = 1'b0;
    $display("step saturate: bubbleCount=0x%04h", bubbleCount_o);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
